usbdev_bufarb: RTL
==================

USBDEV_BUFARB -- requirements
Module: usbdev_bufarb

Interface
REQ-001 Parameter AW, default 6: packet-buffer address width (64 bytes).
REQ-002 Parameter STARVE_MAX, default 4: maximum consecutive SIE grants while a CPU request is pending.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: reset is synchronous and active-high.
REQ-005 Ports sie_req / sie_we, input, 1 each: SIE access request and write strobe.
REQ-006 Ports sie_addr, input, AW; sie_wdata, input, 8: SIE address and write data.
REQ-007 Ports sie_gnt, output, 1; sie_rvalid, output, 1; sie_rdata, output, 8: SIE grant, read-data valid, read data.
REQ-008 Ports cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_gnt, cpu_rvalid, cpu_rdata: CPU-side set, same directions and widths as the SIE set.
REQ-009 Ports ram_en, output, 1; ram_we, output, 1; ram_addr, output, AW; ram_wdata, output, 8: single-port buffer RAM command.
REQ-010 Port ram_rdata, input, 8: RAM read data, valid one cycle after a read command.

Function
REQ-011 At most one requester SHALL be granted per cycle; grant is combinational from current req inputs and registered arbiter state.
REQ-012 A requester SHALL hold req, we, addr, wdata stable until it samples gnt high; its access completes in the gnt cycle.
REQ-013 In the grant cycle, ram_en=1 and ram_we/ram_addr/ram_wdata SHALL equal the granted requester's we/addr/wdata.
REQ-014 With no grant, ram_en, ram_we, ram_addr, ram_wdata SHALL all be 0.
REQ-015 Only sie_req high: SIE granted. Only cpu_req high: CPU granted.
REQ-016 Both high and starve_cnt < STARVE_MAX: SIE granted. Both high and starve_cnt == STARVE_MAX: CPU granted.
REQ-017 starve_cnt (width clog2(STARVE_MAX+1)) SHALL increment when SIE is granted while cpu_req is high, and clear when CPU is granted or cpu_req is low.
REQ-018 starve_cnt SHALL never exceed STARVE_MAX (saturating, no wrap).
REQ-019 Read latency SHALL be one cycle: x_rvalid asserts the cycle after a read grant (x_we=0) to x, for exactly one cycle; x_rvalid stays low after a write grant.
REQ-020 x_rdata SHALL equal ram_rdata while x_rvalid=1 and 0 otherwise.
REQ-021 Back-to-back grants to the same or alternating requesters SHALL be supported every cycle; rvalid pipeline SHALL track each grant independently.
REQ-022 Request dropped before grant: no RAM access, no rvalid, no counter change beyond REQ-017.

Reset
REQ-023 While reset=1 at a clock edge: starve_cnt=0, sie_rvalid=0, cpu_rvalid=0 after the edge.
REQ-024 While reset=1, sie_gnt, cpu_gnt and ram_en SHALL be forced to 0 regardless of req inputs.
REQ-025 Reset asserted the cycle after a read grant SHALL suppress the pending rvalid.
REQ-026 First cycle after reset deasserts SHALL arbitrate normally with starve_cnt=0.

Verification
REQ-027 SIE write addr 0x05 data 0xA5, then SIE read 0x05 -> ram_en/ram_we=1 with 0x05/0xA5 in grant cycle; sie_rvalid next-but-one read cycle+1 with sie_rdata=0xA5.
REQ-028 Both req held continuously, STARVE_MAX=4 -> grants SIE,SIE,SIE,SIE,CPU, pattern repeats; cpu_gnt never two cycles apart less than 5.
REQ-029 Only cpu_req for 10 cycles of reads -> cpu_gnt every cycle, cpu_rvalid every cycle from cycle 2, sie_gnt never high, starve_cnt=0.
REQ-030 SIE read granted cycle N, CPU read granted N+1 -> sie_rvalid at N+1 only, cpu_rvalid at N+2 only, each with its own ram_rdata.
REQ-031 Reset asserted cycle after a CPU read grant, both reqs high -> cpu_rvalid stays 0, no gnt during reset, starve_cnt=0; first post-reset cycle grants SIE.
REQ-032 No requests -> ram_en=0, ram_addr=0, ram_wdata=0, both rvalid=0.

Source files
------------

// File: rtl/usbdev_bufarb.sv
// -----------------------------------------------------------------------------
// usbdev_bufarb
//
// Arbiter between the USB serial interface engine (SIE) and the CPU for a
// single-port packet-buffer RAM. Only one requester is granted in a cycle.
// The SIE normally wins a conflict. A starvation counter makes sure the CPU
// still gets a slot: once the SIE has taken STARVE_MAX grants in a row while
// the CPU was waiting, the next conflicting cycle goes to the CPU.
//
// Each read returns its data one cycle after the grant. Separate per-requester
// valid flags track this, so back-to-back and interleaved reads each return
// to the requester that issued them.
//
// Ports
//   clk, reset                   single clock, synchronous active-high reset
//   sie_req/we/addr/wdata        SIE request; held stable until sie_gnt
//   sie_gnt                      SIE access happens in this cycle
//   sie_rvalid/sie_rdata         SIE read data, one cycle after a read grant
//   cpu_*                        CPU-side set, same meaning as the SIE set
//   ram_en/we/addr/wdata         RAM command (all zero when nothing is granted)
//   ram_rdata                    RAM read data, valid one cycle after a read
// -----------------------------------------------------------------------------
module usbdev_bufarb #(
    parameter int AW         = 6,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          sie_req,
    input  logic          sie_we,
    input  logic [AW-1:0] sie_addr,
    input  logic [7:0]    sie_wdata,
    output logic          sie_gnt,
    output logic          sie_rvalid,
    output logic [7:0]    sie_rdata,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [7:0]    cpu_rdata,

    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_wdata,
    input  logic [7:0]    ram_rdata
);

    localparam int              SCW        = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SCW-1:0]  STARVE_LIM = SCW'(STARVE_MAX);

    logic [SCW-1:0] starve_cnt;
    logic           sie_rv_q;
    logic           cpu_rv_q;
    logic           starve_hit;

    assign starve_hit = (starve_cnt == STARVE_LIM);

    // Grant decision. The CPU wins only when it is alone or when it has been
    // held off long enough. Reset blocks every grant, so no RAM access can
    // start while the block is being reset.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // that no path leaves it unassigned; a missing default infers a latch.
        sie_gnt = 1'b0;
        cpu_gnt = 1'b0;
        if (!reset) begin
            if (cpu_req && (!sie_req || starve_hit)) begin
                cpu_gnt = 1'b1;
            end else if (sie_req) begin
                sie_gnt = 1'b1;
            end
        end
    end

    // RAM command mux. The bus is driven to zero when idle so the RAM
    // interface shows no stale address or data.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (sie_gnt) begin
            ram_en    = 1'b1;
            ram_we    = sie_we;
            ram_addr  = sie_addr;
            ram_wdata = sie_wdata;
        end else if (cpu_gnt) begin
            ram_en    = 1'b1;
            ram_we    = cpu_we;
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments, so every register
    // here samples values from before the edge no matter the statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
            sie_rv_q   <= 1'b0;
            cpu_rv_q   <= 1'b0;
        end else begin
            sie_rv_q <= sie_gnt & ~sie_we;
            cpu_rv_q <= cpu_gnt & ~cpu_we;
            // Count only SIE wins that happen while the CPU is waiting, and
            // saturate at the limit. The CPU wins next, and that clears it.
            if (cpu_gnt || !cpu_req) begin
                starve_cnt <= '0;
            end else if (sie_gnt && !starve_hit) begin
                starve_cnt <= starve_cnt + SCW'(1);
            end
        end
    end

    // Read-valid is also gated by reset. A read granted just before reset
    // asserts never shows its data, even though its flag was already set.
    assign sie_rvalid = sie_rv_q & ~reset;
    assign cpu_rvalid = cpu_rv_q & ~reset;
    assign sie_rdata  = sie_rvalid ? ram_rdata : 8'h00;
    assign cpu_rdata  = cpu_rvalid ? ram_rdata : 8'h00;

endmodule
